// File: rtl/time_tag_decoder.sv
// Time-tag word decoder: classifies merged frontend words, tracks the last period per module
// and emits one status record per time tag. Optional macro: TT_DECODE_STRICT_PAD_EN.
module time_tag_decoder #(
  parameter int CRC_BITS       = 5,
  parameter int MODULE_ID_BITS = 4,
  parameter int PERIOD_BITS    = 48,
  parameter int DATA_BITS      = 128,
  parameter int ERR_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_BITS-1:0]      s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [MODULE_ID_BITS-1:0] m_module_id,
  output logic [PERIOD_BITS-1:0]    m_period,
  output logic [1:0]                m_status,
  output logic [ERR_BITS-1:0]       tag_count,
  output logic [ERR_BITS-1:0]       frame_err_count,
  output logic [ERR_BITS-1:0]       seq_err_count
);

  localparam int DEPTH  = 2**MODULE_ID_BITS;
  localparam int FRM_LO = DATA_BITS - CRC_BITS;
  localparam int SGL    = FRM_LO - 1;
  localparam int ID_HI  = SGL - 1;
  localparam int ID_LO  = ID_HI - MODULE_ID_BITS + 1;
  localparam int BLK_HI = ID_LO - 1;
  localparam int BLK_LO = BLK_HI - 1;
  localparam int CMD    = BLK_LO - 1;

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_SYNC = 2'd1, ST_GAP = 2'd2, ST_BACK = 2'd3} status_e;

  logic [PERIOD_BITS-1:0]    last_q [DEPTH];
  logic [PERIOD_BITS-1:0]    last_d [DEPTH];
  logic [DEPTH-1:0]          seen_q, seen_d;
  logic                      m_valid_q, m_valid_d;
  logic [MODULE_ID_BITS-1:0] m_module_id_q, m_module_id_d;
  logic [PERIOD_BITS-1:0]    m_period_q, m_period_d;
  status_e                   m_status_q, m_status_d;
  logic [ERR_BITS-1:0]       tag_count_q, tag_count_d;
  logic [ERR_BITS-1:0]       frame_err_count_q, frame_err_count_d;
  logic [ERR_BITS-1:0]       seq_err_count_q, seq_err_count_d;

  logic                      xfer, framing_ok, non_tag, pad_err, is_tag, frame_err, seq_err;
  logic [MODULE_ID_BITS-1:0] id;
  logic [PERIOD_BITS-1:0]    period, last_m, last_inc;
  status_e                   status;

  function automatic logic [ERR_BITS-1:0] sat_inc(input logic [ERR_BITS-1:0] v, input logic en);
    return (en && (v != '1)) ? v + ERR_BITS'(1) : v;
  endfunction

  assign s_ready    = ~m_valid_q | m_ready;
  assign xfer       = s_valid & s_ready;
  assign framing_ok = &s_data[DATA_BITS-1:FRM_LO];
  assign non_tag    = s_data[SGL] | (|s_data[BLK_HI:BLK_LO]) | s_data[CMD];
  assign id         = s_data[ID_HI:ID_LO];
  assign period     = s_data[PERIOD_BITS-1:0];

`ifdef TT_DECODE_STRICT_PAD_EN
  assign pad_err = framing_ok & ~non_tag & (|s_data[CMD-1:PERIOD_BITS]);
`else
  logic unused_pad;
  assign unused_pad = |s_data[CMD-1:PERIOD_BITS];
  assign pad_err    = 1'b0;
`endif

  assign is_tag    = xfer & framing_ok & ~non_tag & ~pad_err;
  assign frame_err = xfer & (~framing_ok | pad_err);
  assign last_m    = last_q[id];
  assign last_inc  = last_m + PERIOD_BITS'(1);

  // The modular +1 check comes before P==0 so an all-ones -> 0 wrap reports OK.
  always_comb begin
    status = ST_SYNC;
    if (!seen_q[id])             status = ST_SYNC;
    else if (period == last_inc) status = ST_OK;
    else if (period == '0)       status = ST_SYNC;
    else if (period > last_m)    status = ST_GAP;
    else                         status = ST_BACK;
  end

  assign seq_err = is_tag & ((status == ST_GAP) | (status == ST_BACK));

  always_comb begin
    seen_d        = seen_q;
    last_d        = last_q;
    m_valid_d     = m_valid_q & ~m_ready;
    m_module_id_d = m_module_id_q;
    m_period_d    = m_period_q;
    m_status_d    = m_status_q;
    if (is_tag) begin
      seen_d[id]    = 1'b1;
      last_d[id]    = period;
      m_valid_d     = 1'b1;
      m_module_id_d = id;
      m_period_d    = period;
      m_status_d    = status;
    end
    tag_count_d       = sat_inc(tag_count_q, is_tag);
    frame_err_count_d = sat_inc(frame_err_count_q, frame_err);
    seq_err_count_d   = sat_inc(seq_err_count_q, seq_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q            <= '0;
      for (int i = 0; i < DEPTH; i++) last_q[i] <= '0;
      m_valid_q         <= 1'b0;
      m_module_id_q     <= '0;
      m_period_q        <= '0;
      m_status_q        <= ST_OK;
      tag_count_q       <= '0;
      frame_err_count_q <= '0;
      seq_err_count_q   <= '0;
    end else begin
      seen_q            <= seen_d;
      last_q            <= last_d;
      m_valid_q         <= m_valid_d;
      m_module_id_q     <= m_module_id_d;
      m_period_q        <= m_period_d;
      m_status_q        <= m_status_d;
      tag_count_q       <= tag_count_d;
      frame_err_count_q <= frame_err_count_d;
      seq_err_count_q   <= seq_err_count_d;
    end
  end

  assign m_valid         = m_valid_q;
  assign m_module_id     = m_module_id_q;
  assign m_period        = m_period_q;
  assign m_status        = m_status_q;
  assign tag_count       = tag_count_q;
  assign frame_err_count = frame_err_count_q;
  assign seq_err_count   = seq_err_count_q;

endmodule

// File: tb/tb_time_tag_decoder.sv
// Scoreboard bench for time_tag_decoder; expected records are queued on transfer and checked on output handshake.
module tb_time_tag_decoder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [3:0]   m_module_id;
  logic [47:0]  m_period;
  logic [1:0]   m_status;
  logic [15:0]  tag_count, frame_err_count, seq_err_count;

  time_tag_decoder dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_module_id(m_module_id), .m_period(m_period),
    .m_status(m_status), .tag_count(tag_count), .frame_err_count(frame_err_count),
    .seq_err_count(seq_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] id; logic [47:0] p; logic [1:0] st;} rec_t;
  rec_t        exp_q[$];
  logic        mdl_seen [16];
  logic [47:0] mdl_last [16];
  int          mdl_tag, mdl_fe, mdl_seq;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [4:0] frm, input logic sgl, input logic [3:0] id,
                                      input logic [1:0] blk, input logic cmd, input logic pad,
                                      input logic [47:0] p);
    logic [127:0] w;
    w = '0;
    w[127:123] = frm; w[122] = sgl; w[121:118] = id; w[117:116] = blk; w[115] = cmd;
    w[60] = pad; w[47:0] = p;
    return w;
  endfunction

  function automatic logic [127:0] tag(input logic [3:0] id, input logic [47:0] p);
    return mk(5'h1F, 1'b0, id, 2'b0, 1'b0, 1'b0, p);
  endfunction

  function automatic logic [15:0] sat(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin mdl_seen[i] = 1'b0; mdl_last[i] = '0; end
    mdl_tag = 0; mdl_fe = 0; mdl_seq = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [127:0] w);
    logic [3:0]  id;
    logic [47:0] p;
    rec_t        r;
    id = w[121:118];
    p  = w[47:0];
    if (w[127:123] != 5'h1F) begin mdl_fe++; return; end
    if (w[122] || w[117:116] != 2'b0 || w[115]) return;
`ifdef TT_DECODE_STRICT_PAD_EN
    if (w[114:48] != '0) begin mdl_fe++; return; end
`endif
    if (!mdl_seen[id])                  r.st = 2'd1;
    else if (p == mdl_last[id] + 48'd1) r.st = 2'd0;
    else if (p == 48'd0)                r.st = 2'd1;
    else if (p > mdl_last[id])          r.st = 2'd2;
    else                                r.st = 2'd3;
    r.id = id; r.p = p;
    exp_q.push_back(r);
    mdl_seen[id] = 1'b1;
    mdl_last[id] = p;
    mdl_tag++;
    if (r.st >= 2'd2) mdl_seq++;
  endtask

  task automatic send(input logic [127:0] w);
    bit got;
    got = 0;
    s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin model_accept(w); got = 1; break; end
    end
    if (!got) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_tag_cnt"}, 64'(tag_count), 64'(sat(mdl_tag)));
    chk({tag, "_fe_cnt"}, 64'(frame_err_count), 64'(sat(mdl_fe)));
    chk({tag, "_seq_cnt"}, 64'(seq_err_count), 64'(sat(mdl_seq)));
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_record", 64'd1, 64'd0);
      else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("rec_id", 64'(m_module_id), 64'(r.id));
        chk("rec_period", 64'(m_period), 64'(r.p));
        chk("rec_status", 64'(m_status), 64'(r.st));
      end
    end
  end

  initial begin
    int n1;
    bit seen_v;
    model_clear();
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_period", 64'(m_period), 64'd0);
    chk_counters("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // module 3 at full rate: SYNC, OK, OK
    send(tag(4'd3, 48'd0)); send(tag(4'd3, 48'd1)); send(tag(4'd3, 48'd2));
    idle(3);
    chk_counters("m3");
    chk("m3_tag_const", 64'(tag_count), 64'd3);

    // module 5: SYNC, GAP, BACKWARD, OK
    send(tag(4'd5, 48'd10)); send(tag(4'd5, 48'd13));
    idle(2);
    chk("m5_gap_seq", 64'(seq_err_count), 64'd1);
    send(tag(4'd5, 48'd7));
    idle(2);
    chk("m5_back_seq", 64'(seq_err_count), 64'd2);
    send(tag(4'd5, 48'd8));

    // wrap and frontend-reset sync
    send(tag(4'd1, 48'hFFFF_FFFF_FFFF)); send(tag(4'd1, 48'd0));
    send(tag(4'd2, 48'd500)); send(tag(4'd2, 48'd0));
    idle(3);
    chk_counters("wrap");

    // bad framing, command word, padded tag
    send(mk(5'b11110, 1'b0, 4'd3, 2'b0, 1'b0, 1'b0, 48'd3));
    idle(1);
    chk("fe_m_valid", 64'(m_valid), 64'd0);
    chk("fe_count", 64'(frame_err_count), 64'd1);
    send(mk(5'h1F, 1'b0, 4'd3, 2'b0, 1'b1, 1'b0, 48'd3));
    send(mk(5'h1F, 1'b1, 4'd3, 2'b0, 1'b0, 1'b0, 48'd3));
    send(mk(5'h1F, 1'b0, 4'd3, 2'b10, 1'b0, 1'b0, 48'd3));
    idle(2);
    chk_counters("nontag");
    send(mk(5'h1F, 1'b0, 4'd4, 2'b0, 1'b0, 1'b1, 48'd1));
    send(tag(4'd3, 48'd3));
    idle(3);
    chk_counters("pad");

    // back-pressure: record held, s_ready low, then drain in order
    m_ready = 1'b0;
    fork
      begin
        send(tag(4'd6, 48'd1)); send(tag(4'd6, 48'd2));
        send(tag(4'd6, 48'd4)); send(tag(4'd6, 48'd5));
      end
      begin
        seen_v = 0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
          @(negedge clk);
          seen_v = m_valid;
        end
        chk("stall_m_valid_seen", 64'(seen_v), 64'd1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_s_ready", 64'(s_ready), 64'd0);
          chk("stall_period", 64'(m_period), 64'd1);
          chk("stall_id", 64'(m_module_id), 64'd6);
          chk("stall_tag_cnt", 64'(tag_count), 64'(sat(mdl_tag)));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    idle(3);
    chk_counters("stall");

    // frame-error saturation
    n1 = 65534 - mdl_fe;
    s_data = mk(5'b01111, 1'b0, 4'd0, 2'b0, 1'b0, 1'b0, 48'd0);
    s_valid = 1'b1;
    repeat (n1) @(posedge clk);
    #1;
    s_valid = 1'b0;
    mdl_fe += n1;
    chk("sat_fffe", 64'(frame_err_count), 64'hFFFE);
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    mdl_fe += 5;
    chk("sat_ffff", 64'(frame_err_count), 64'hFFFF);
    chk_counters("sat");

    // asynchronous reset with a record held in the output register
    m_ready = 1'b0;
    send(tag(4'd7, 48'd9));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_m_id", 64'(m_module_id), 64'd0);
    chk("arst_m_period", 64'(m_period), 64'd0);
    chk("arst_m_status", 64'(m_status), 64'd0);
    model_clear();
    chk_counters("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(tag(4'd7, 48'd10)); send(tag(4'd3, 48'd4)); send(tag(4'd3, 48'd5));
    idle(3);
    chk_counters("post");
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/time_tag_decoder.md
# time_tag_decoder

Backend-side decoder for the 128-bit time-tag words emitted by each frontend module at every period boundary. Accepts the merged word stream and separates valid time tags from event, command and malformed words. Tracks the last 48-bit period per module ID and emits one registered status record per time tag for the coincidence/sorting logic. Keeps saturating error counters for link diagnostics.

## Interface
- CRC_BITS, 5, width of framing field (must be all ones)
- MODULE_ID_BITS, 4, module ID width; table depth = 2**MODULE_ID_BITS
- PERIOD_BITS, 48, time-tag period counter width
- DATA_BITS, 128, input word width
- ERR_BITS, 16, width of each saturating counter

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  DATA_BITS  input word
- s_valid  in  1  input word valid
- s_ready  out  1  input ready
- m_valid  out  1  tag record valid
- m_ready  in  1  downstream ready
- m_module_id  out  MODULE_ID_BITS  module ID of record
- m_period  out  PERIOD_BITS  decoded period
- m_status  out  2  0=OK, 1=SYNC, 2=GAP, 3=BACKWARD
- tag_count  out  ERR_BITS  accepted time tags, saturating
- frame_err_count  out  ERR_BITS  words with bad framing, saturating
- seq_err_count  out  ERR_BITS  GAP+BACKWARD records, saturating

## Operation
- Word fields (MSB first): [127:123] framing, [122] single-event flag, [121:118] module ID, [117:116] block ID, [115] command flag, [114:48] padding, [47:0] period.
- Transfer occurs when s_valid & s_ready. Classification is combinational on s_data at transfer:
  - framing != all ones: frame error; frame_err_count +1; no record.
  - framing ok, and single flag, block ID or command flag nonzero: non-tag word; consumed silently.
  - otherwise: time tag.
- Per-module table: seen bit + last period (PERIOD_BITS). Time tag for module m with period P:
  - !seen[m]: status SYNC; seen[m]<=1.
  - P == 0: status SYNC (frontend reset); no seq error.
  - P == last[m]+1 (modulo 2**PERIOD_BITS, so all-ones to 0 wraps as OK, taking precedence over the P==0 rule): status OK.
  - P > last[m]+1: GAP. P <= last[m] (nonzero): BACKWARD. Both increment seq_err_count.
  - last[m]<=P in every case.
- Table updates at the transfer edge; back-to-back tags for the same module use the updated value.
- Counters saturate at all ones; no wrap.

## Timing
- Reset (rst_n low, async): m_valid=0, m_module_id=0, m_period=0, m_status=0, all counters 0, all seen bits 0, table periods 0. s_ready=1 once reset is released.
- s_ready = ~m_valid | m_ready (combinational; single output register, no skid).
- Latency: time tag transferred on cycle N produces m_valid=1 on cycle N+1; record held stable until m_valid & m_ready.
- Full throughput: one word per cycle while m_ready=1.
- Non-tag and frame-error words are accepted under the same s_ready rule but produce no record; if the output register is empty afterwards, m_valid drops.
- Output handshake and a new tag on the same cycle: output register reloads; m_valid stays 1.
- Counter increments coincide with the transfer edge.
- rst_n asserted mid-stream: in-flight record dropped, table cleared; first tag per module afterwards reports SYNC.

## Configuration
- TT_DECODE_STRICT_PAD_EN defined: a word with good framing, zero flags, zero block ID but nonzero padding counts as a frame error (frame_err_count +1, no record, table untouched).
- Undefined: padding ignored; such a word decodes as a normal time tag.

## Test plan
- Reset, then tags for module 3 with periods 0,1,2 at full rate, m_ready=1 -> records SYNC,OK,OK at cycles N+1..N+3; tag_count=3; seq_err_count=0.
- Module 5 periods 10 then 13 -> SYNC then GAP; seq_err_count=1. Then period 7 -> BACKWARD; seq_err_count=2; next period 8 -> OK.
- Module 1 at period 48'hFFFF_FFFF_FFFF, then 0 -> OK (wrap). Module 2 at 500, then 0 -> SYNC, no seq error.
- Framing 5'b11110 word -> frame_err_count=1, no m_valid. Word with command flag=1 -> consumed, no record, counters unchanged. Nonzero padding tag -> frame error with TT_DECODE_STRICT_PAD_EN, OK/SYNC record without.
- m_ready held low 4 cycles with s_valid high -> s_ready low after first record, record stable, no table or counter change; release -> remaining tags drain in order, no loss or duplication.
- Drive frame errors past 2**ERR_BITS-1 -> frame_err_count holds 16'hFFFF; assert rst_n low mid-stream -> all outputs and counters 0 asynchronously.
